mem_store_monitor: RTL and testbench

- Hardware responder on the CPU data-memory store interface (`MemWrite` / `DataAdr` / `WriteData`) of the single-cycle ARM core on the DE10-Lite.
- Snoops every store and logs address/data pairs into a small FIFO.
- Decides PASS/FAIL when the program writes its completion address, or TIMEOUT after a cycle budget.
- Makes the on-board self-check synthesizable and readable by LEDs, 7-seg or a debug reader, instead of relying on a simulation bench.

---
 rtl/store_mon_pkg.sv | 22 ++
 rtl/store_fifo.sv | 61 ++++++
 rtl/mem_store_monitor.sv | 107 ++++++++++
 tb/tb_mem_store_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/store_mon_pkg.sv
// Shared types for the store monitor: run status encoding and the
// logged store entry. No ports; imported by store_fifo and mem_store_monitor.
package store_mon_pkg;

   localparam int ADR_W  = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PASS    = 2'd1,
      FAIL    = 2'd2,
      TIMEOUT = 2'd3
   } status_e;

   typedef struct packed {
      logic [ADR_W-1:0]  adr;
      logic [DATA_W-1:0] data;
   } store_entry_t;

   localparam int ENTRY_W = $bits(store_entry_t);

endpackage

// File: rtl/store_fifo.sv
// Log FIFO with registered output; pops are ignored when empty and a push
// is accepted when full only if a pop frees a slot on the same edge.
// Ports: clk, rst_n (async, active-low), push, pop, din, dout, count,
// full, empty.
module store_fifo
   import store_mon_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter type entry_t = store_entry_t,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  entry_t        din,
   output entry_t        dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_push;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage needs no reset; only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout   <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_store_monitor.sv
// Snoops CPU stores, logs them, and decides PASS/FAIL/TIMEOUT.
// Ports: clk, reset (async, active-low), mem_write, data_adr, write_data,
// rd_en -> rd_valid, rd_adr, rd_data, fifo_count, overflow, status,
// cycle_count. Define STORE_MON_ALIGN_CHECK_EN to fail on unaligned stores.
module mem_store_monitor
   import store_mon_pkg::*;
#(
   parameter logic [31:0] DONE_ADDR      = 32'h0000_0064,
   parameter logic [31:0] DONE_VALUE     = 32'd7,
   parameter int          TIMEOUT_CYCLES = 100,
   parameter int          FIFO_DEPTH     = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        mem_write,
   input  logic [31:0]                 data_adr,
   input  logic [31:0]                 write_data,
   input  logic                        rd_en,
   output logic                        rd_valid,
   output logic [31:0]                 rd_adr,
   output logic [31:0]                 rd_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic [1:0]                  status,
   output logic [31:0]                 cycle_count
);

   status_e      state;
   status_e      state_nxt;
   store_entry_t din;
   store_entry_t dout;
   logic         full;
   logic         empty;
   logic         push_req;
   logic         pop_act;
   logic         dropped;
   logic         done_hit;
   logic         misaligned;
   logic         at_limit;

   assign din.adr  = data_adr;
   assign din.data = write_data;

   assign push_req = mem_write && (state == RUN);
   assign pop_act  = rd_en && !empty;
   // A full FIFO still accepts the push if a pop drains a slot this edge.
   assign dropped  = push_req && full && !pop_act;
   assign done_hit = mem_write && (data_adr == DONE_ADDR);
   assign at_limit = (cycle_count == 32'(TIMEOUT_CYCLES - 1));

`ifdef STORE_MON_ALIGN_CHECK_EN
   assign misaligned = mem_write && (data_adr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   store_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (store_entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push_req),
      .pop   (rd_en),
      .din   (din),
      .dout  (dout),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   assign rd_adr  = dout.adr;
   assign rd_data = dout.data;
   assign status  = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= state_nxt;
   end

   // Done-store outranks the alignment check, which outranks timeout.
   always_comb begin
      state_nxt = state;
      if (state == RUN) begin
         if (done_hit)
            state_nxt = (write_data == DONE_VALUE) ? PASS : FAIL;
         else if (misaligned)
            state_nxt = FAIL;
         else if (at_limit)
            state_nxt = TIMEOUT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_count <= '0;
         overflow    <= 1'b0;
         rd_valid    <= 1'b0;
      end else begin
         rd_valid <= pop_act;
         if (dropped) overflow <= 1'b1;
         if (state == RUN && cycle_count != '1)
            cycle_count <= cycle_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_store_monitor.sv
// Directed bench for mem_store_monitor with hand-computed expectations.
// No ports; drives and samples the DUT 2 time units after each rising edge.
module tb_mem_store_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_write;
   logic [31:0] data_adr;
   logic [31:0] write_data;
   logic        rd_en;
   logic        rd_valid;
   logic [31:0] rd_adr;
   logic [31:0] rd_data;
   logic [3:0]  fifo_count;
   logic        overflow;
   logic [1:0]  status;
   logic [31:0] cycle_count;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_align;

   always #5 clk = ~clk;

   mem_store_monitor dut (
      .clk         (clk),
      .reset       (reset),
      .mem_write   (mem_write),
      .data_adr    (data_adr),
      .write_data  (write_data),
      .rd_en       (rd_en),
      .rd_valid    (rd_valid),
      .rd_adr      (rd_adr),
      .rd_data     (rd_data),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .status      (status),
      .cycle_count (cycle_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_write  = 1'b1;
      data_adr   = a;
      write_data = d;
      tick();
      mem_write  = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset      = 1'b0;
      mem_write  = 1'b0;
      data_adr   = '0;
      write_data = '0;
      rd_en      = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_status", status, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_cyc", cycle_count, 0);
      chk("rst_adr", rd_adr, 0);
      chk("rst_data", rd_data, 0);
      reset = 1'b1;

      // PASS run with three logged stores
      store(32'h10, 32'd5);
      chk("p_st1", status, 0);
      store(32'h14, 32'd9);
      chk("p_st2", status, 0);
      store(32'h64, 32'd7);
      chk("p_status", status, 1);
      chk("p_count", fifo_count, 3);
      chk("p_cyc", cycle_count, 3);
      pop();
      chk("p_v0", rd_valid, 1);
      chk("p_a0", rd_adr, 32'h10);
      chk("p_d0", rd_data, 32'd5);
      chk("p_c0", fifo_count, 2);
      pop();
      chk("p_a1", rd_adr, 32'h14);
      chk("p_d1", rd_data, 32'd9);
      pop();
      chk("p_a2", rd_adr, 32'h64);
      chk("p_d2", rd_data, 32'd7);
      chk("p_c2", fifo_count, 0);
      pop();
      chk("p_empty_v", rd_valid, 0);
      chk("p_hold_a", rd_adr, 32'h64);
      chk("p_hold_d", rd_data, 32'd7);
      chk("p_frozen", cycle_count, 3);

      // FAIL, later stores ignored
      do_reset();
      store(32'h64, 32'd8);
      chk("f_status", status, 2);
      chk("f_count", fifo_count, 1);
      store(32'h64, 32'd7);
      chk("f_hold", status, 2);
      chk("f_count2", fifo_count, 1);

      // TIMEOUT
      do_reset();
      repeat (99) tick();
      chk("t_pre_st", status, 0);
      chk("t_pre_cyc", cycle_count, 99);
      tick();
      chk("t_status", status, 3);
      chk("t_cyc", cycle_count, 100);
      repeat (5) tick();
      chk("t_frozen", cycle_count, 100);
      chk("t_hold", status, 3);

      // Done-store on the timeout cycle wins
      do_reset();
      repeat (99) tick();
      store(32'h64, 32'd7);
      chk("dt_status", status, 1);
      chk("dt_cyc", cycle_count, 100);

      // Overflow and push+pop while full
      do_reset();
      for (int i = 0; i < 10; i++) store(32'h100 + 32'(4 * i), 32'(i));
      chk("o_count", fifo_count, 8);
      chk("o_ovf", overflow, 1);
      chk("o_status", status, 0);
      mem_write  = 1'b1;
      data_adr   = 32'h200;
      write_data = 32'hAA;
      rd_en      = 1'b1;
      tick();
      mem_write  = 1'b0;
      chk("o_pp_count", fifo_count, 8);
      chk("o_pp_valid", rd_valid, 1);
      chk("o_a0", rd_adr, 32'h100);
      chk("o_d0", rd_data, 32'd0);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("o_adr", rd_adr, 32'h100 + 32'(4 * i));
         chk("o_data", rd_data, 32'(i));
      end
      tick();
      rd_en = 1'b0;
      chk("o_last_a", rd_adr, 32'h200);
      chk("o_last_d", rd_data, 32'hAA);
      chk("o_drained", fifo_count, 0);
      chk("o_sticky", overflow, 1);

      // Reset mid-run
      do_reset();
      for (int i = 0; i < 4; i++) store(32'h40 + 32'(4 * i), 32'(i + 1));
      chk("r_count4", fifo_count, 4);
      pop();
      chk("r_valid1", rd_valid, 1);
      chk("r_count3", fifo_count, 3);
      reset = 1'b0;
      #1;
      chk("r_count", fifo_count, 0);
      chk("r_status", status, 0);
      chk("r_ovf", overflow, 0);
      chk("r_valid", rd_valid, 0);
      chk("r_cyc", cycle_count, 0);
      chk("r_adr", rd_adr, 0);
      tick();
      reset = 1'b1;
      pop();
      chk("r_empty_pop", rd_valid, 0);
      chk("r_empty_cnt", fifo_count, 0);

      // Unaligned store
      do_reset();
`ifdef STORE_MON_ALIGN_CHECK_EN
      exp_align = 32'd2;
`else
      exp_align = 32'd0;
`endif
      store(32'h22, 32'd1);
      chk("a_status", status, exp_align);
      chk("a_count", fifo_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
